lm80c_ps2_matrix: RTL and testbench

//  PS/2 keyboard front end producing the 8x8 active-low key matrix read by the PSG

---
 rtl/lm80c_kbd_pkg.sv | 23 ++
 rtl/lm80c_ps2_keymap.sv | 23 ++
 rtl/lm80c_ps2_matrix.sv | 207 ++++++++++++++++++++
 tb/tb_lm80c_ps2_matrix.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/lm80c_kbd_pkg.sv
// Shared types and scancode constants for the LM80C PS/2 keyboard front end.
package lm80c_kbd_pkg;

  typedef logic [7:0][7:0] km_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_BAT   = 8'hAA;

  // PS/2 frames carry odd parity over the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/lm80c_ps2_keymap.sv
// Scancode to key-matrix position lookup; {ext,code} -> {hit,row,col}.
module lm80c_ps2_keymap (
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output logic [2:0] row,
  output logic [2:0] col
);

  always_comb begin
    hit = 1'b1;
    row = 3'd0;
    col = 3'd0;
    case ({ext, code})
      9'h01C: begin row = 3'd2; col = 3'd1; end  // A
      9'h012: begin row = 3'd0; col = 3'd7; end  // left shift
      9'h05A: begin row = 3'd6; col = 3'd0; end  // enter
      9'h175: begin row = 3'd7; col = 3'd3; end  // cursor up (E0 75)
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/lm80c_ps2_matrix.sv
// PS/2 set-2 receiver and decoder driving the 8x8 active-low keyboard matrix.
// Optional ps2_clk glitch filter enabled by defining PS2_CLK_FILTER_EN.
module lm80c_ps2_matrix
  import lm80c_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 85000
`ifdef PS2_CLK_FILTER_EN
  , parameter int FILTER_LEN = 8
`endif
) (
  input  logic            sys_clock,
  input  logic            reset_n,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  output logic [7:0][7:0] km,
  output logic [7:0]      scan_code,
  output logic            scan_strobe,
  output logic            parity_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic            dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic            clk_prev_q, clk_prev_d;
  logic            clk_lvl, clk_fall;

  rx_state_t       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      scan_code_q, scan_code_d;
  logic            scan_strobe_q, scan_strobe_d;
  logic            parity_err_q, parity_err_d;

  km_t             km_q, km_d;
  logic            ext_q, ext_d, brk_q, brk_d;
  logic [2:0]      skip_q, skip_d;

  logic            map_hit;
  logic [2:0]      map_row, map_col;

`ifdef PS2_CLK_FILTER_EN
  logic [FILTER_LEN-1:0] filt_sh_q, filt_sh_d;
  logic                  filt_lvl_q, filt_lvl_d;

  // Level only moves once every sample in the window agrees.
  always_comb begin
    filt_sh_d  = {filt_sh_q[FILTER_LEN-2:0], clk_s2_q};
    filt_lvl_d = filt_lvl_q;
    if (&filt_sh_q)       filt_lvl_d = 1'b1;
    else if (~|filt_sh_q) filt_lvl_d = 1'b0;
  end

  always_ff @(posedge sys_clock) begin
    if (!reset_n) begin
      filt_sh_q  <= '1;
      filt_lvl_q <= 1'b1;
    end else begin
      filt_sh_q  <= filt_sh_d;
      filt_lvl_q <= filt_lvl_d;
    end
  end

  assign clk_lvl = filt_lvl_q;
`else
  assign clk_lvl = clk_s2_q;
`endif

  assign clk_fall = clk_prev_q & ~clk_lvl;

  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    clk_prev_d = clk_lvl;
  end

  // Receive FSM: one step per ps2_clk fall, with an inactivity abort.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    timer_d       = timer_q;
    scan_code_d   = scan_code_q;
    scan_strobe_d = 1'b0;
    parity_err_d  = 1'b0;

    if (state_q == IDLE || clk_fall) timer_d = '0;
    else                             timer_d = timer_q + 1'b1;

    if (clk_fall) begin
      case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          if (dat_s2_q && odd_parity_ok(shift_q, par_q)) begin
            scan_code_d   = shift_q;
            scan_strobe_d = 1'b1;
          end else begin
            parity_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && timer_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d      = IDLE;
      parity_err_d = 1'b1;
    end
  end

  lm80c_ps2_keymap u_keymap (
    .ext  (ext_q),
    .code (scan_code_q),
    .hit  (map_hit),
    .row  (map_row),
    .col  (map_col)
  );

  // Decoder acts on the registered strobe, so km moves one cycle after it.
  always_comb begin
    km_d   = km_q;
    ext_d  = ext_q;
    brk_d  = brk_q;
    skip_d = skip_q;
    if (scan_strobe_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (scan_code_q)
          SC_EXT:   ext_d  = 1'b1;
          SC_BRK:   brk_d  = 1'b1;
          SC_PAUSE: skip_d = 3'd7;
          default: begin
            if (scan_code_q == SC_BAT && !brk_q) km_d = '1;
            else if (map_hit)                    km_d[map_row][map_col] = brk_q;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge sys_clock) begin
    if (!reset_n) begin
      clk_s1_q      <= 1'b1;
      clk_s2_q      <= 1'b1;
      dat_s1_q      <= 1'b1;
      dat_s2_q      <= 1'b1;
      clk_prev_q    <= 1'b1;
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      par_q         <= 1'b0;
      timer_q       <= '0;
      scan_code_q   <= 8'h00;
      scan_strobe_q <= 1'b0;
      parity_err_q  <= 1'b0;
      km_q          <= '1;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      skip_q        <= 3'd0;
    end else begin
      clk_s1_q      <= clk_s1_d;
      clk_s2_q      <= clk_s2_d;
      dat_s1_q      <= dat_s1_d;
      dat_s2_q      <= dat_s2_d;
      clk_prev_q    <= clk_prev_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      timer_q       <= timer_d;
      scan_code_q   <= scan_code_d;
      scan_strobe_q <= scan_strobe_d;
      parity_err_q  <= parity_err_d;
      km_q          <= km_d;
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      skip_q        <= skip_d;
    end
  end

  assign km          = km_q;
  assign scan_code   = scan_code_q;
  assign scan_strobe = scan_strobe_q;
  assign parity_err  = parity_err_q;

endmodule

// File: tb/tb_lm80c_ps2_matrix.sv
// Scoreboard bench for lm80c_ps2_matrix: frames queue their expected event, a monitor checks it.
module tb_lm80c_ps2_matrix;

  localparam int TO = 2000;

  logic            sys_clock = 1'b0;
  logic            reset_n   = 1'b0;
  logic            ps2_clk   = 1'b1;
  logic            ps2_data  = 1'b1;
  logic [7:0][7:0] km;
  logic [7:0]      scan_code;
  logic            scan_strobe;
  logic            parity_err;

  lm80c_ps2_matrix #(.TIMEOUT_CYC(TO)) dut (
    .sys_clock   (sys_clock),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .km          (km),
    .scan_code   (scan_code),
    .scan_strobe (scan_strobe),
    .parity_err  (parity_err)
  );

  always #5 sys_clock = ~sys_clock;

  typedef struct {
    bit          is_err;
    logic [7:0]  code;
    logic [63:0] km;
  } exp_t;

  exp_t            q[$];
  int              checks = 0;
  int              errors = 0;
  logic [7:0][7:0] exp_km;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clock);
  endtask

  // Data changes mid-high, clock low for 16 cycles; optional 2-cycle low glitch after the rise.
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    wait_clk(8);
    ps2_clk = 1'b0;
    wait_clk(16);
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_clk(2);
      ps2_clk = 1'b0;
      wait_clk(2);
      ps2_clk = 1'b1;
      wait_clk(4);
    end else begin
      wait_clk(8);
    end
  endtask

  task automatic send(input logic [7:0] code, input bit bad_par = 1'b0, input bit glitch = 1'b0);
    logic par;
    q.push_back('{bad_par, code, exp_km});
    par = ~^code ^ bad_par;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i], glitch && i == 3);
    ps2_bit(par, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    wait_clk(30);
  endtask

  // Monitor: every strobe/error pulse must match the head of the queue.
  initial begin
    exp_t e;
    wait (reset_n === 1'b1);
    forever begin
      @(negedge sys_clock);
      if (scan_strobe === 1'b1 || parity_err === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {62'b0, scan_strobe, parity_err}, 64'd0);
        end else begin
          e = q.pop_front();
          chk("event_kind", {62'b0, scan_strobe, parity_err}, e.is_err ? 64'd1 : 64'd2);
          if (!e.is_err) chk("scan_code", {56'b0, scan_code}, {56'b0, e.code});
          @(negedge sys_clock);
          chk("pulse_width", {62'b0, scan_strobe, parity_err}, 64'd0);
          chk("km", km, e.km);
        end
      end
    end
  end

  initial begin
    exp_km = '1;
    reset_n = 1'b0;
    wait_clk(3);
    chk("reset_km", km, {64{1'b1}});
    chk("reset_strobe", {63'b0, scan_strobe}, 64'd0);
    chk("reset_perr", {63'b0, parity_err}, 64'd0);
    chk("reset_code", {56'b0, scan_code}, 64'd0);
    reset_n = 1'b1;
    wait_clk(10);

    exp_km[2][1] = 1'b0; send(8'h1C);
    send(8'hF0); exp_km[2][1] = 1'b1; send(8'h1C);
    send(8'hE0); exp_km[7][3] = 1'b0; send(8'h75);
    send(8'hE0); send(8'hF0); exp_km[7][3] = 1'b1; send(8'h75);

    send(8'h1C, 1'b1);

    // Open frame abandoned after the start bit and three data bits.
    q.push_back('{1'b1, 8'h00, exp_km});
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    wait_clk(TO + 50);
    exp_km[6][0] = 1'b0; send(8'h5A);

    exp_km[0][7] = 1'b0; send(8'h12);
    exp_km[2][1] = 1'b0; send(8'h1C);
    send(8'hE1);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    send(8'hE0); send(8'h75); send(8'h1C);
    exp_km = '1; send(8'hAA);

    exp_km[2][1] = 1'b0; send(8'h1C);
    send(8'hF0); send(8'hAA);
    exp_km[6][0] = 1'b0; send(8'h5A);

`ifdef PS2_CLK_FILTER_EN
    exp_km[0][7] = 1'b0; send(8'h12, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 500 && q.size() != 0; i++) wait_clk(1);
    chk("queue_drained", 64'(q.size()), 64'd0);
    wait_clk(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
